// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for the decode-stage immediate generator.
// Input side: a beat transfers on the rising edge where in_valid && in_ready.
// Output side: a beat transfers on the rising edge where out_valid && out_ready.
// A valid, once raised, holds with its payload stable until the transfer edge;
// ready may change freely and is never a combinational function of valid.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic [31:0]      In;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] in_tag;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  Imm_Ext;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;
  logic             out_valid;
  logic             out_ready;

  // Upstream/downstream side (driver of instructions, consumer of immediates)
  modport master (
    output In, ImmSrc, in_tag, in_valid, out_ready,
    input  in_ready, Imm_Ext, out_tag, illegal, out_valid
  );

  // Immediate-generator side
  modport slave (
    input  In, ImmSrc, in_tag, in_valid, out_ready,
    output in_ready, Imm_Ext, out_tag, illegal, out_valid
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator (I/S/B/U/J/CSR-uimm) followed by a
// 2-entry skid buffer. in_ready and out_valid come straight from flops so the
// execute stage's back-pressure never forms a combinational path upstream.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  imm_gen_stage_if.slave bus
);

  // Decoded input beat
  logic [31:0]      dec_raw;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  // Main entry drives the outputs; skid catches one beat under back-pressure
  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;
  logic             in_ready_q,   in_ready_d;

  logic             in_fire;
  logic             out_fire;

  // Opcode bits never contribute to any immediate
  logic             unused_opcode;
  assign unused_opcode = ^bus.In[6:0];

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = main_valid_q && bus.out_ready;

  // Expand the selected format to 32 bits, then extend bit 31 up to XLEN.
  // Z and reserved leave bit 31 clear, so the same extension zero-fills them.
  always_comb begin
    dec_raw = '0;
    dec_ill = 1'b0;
    case (bus.ImmSrc)
      3'b000: dec_raw = {{20{bus.In[31]}}, bus.In[31:20]};
      3'b001: dec_raw = {{20{bus.In[31]}}, bus.In[31:25], bus.In[11:7]};
      3'b010: dec_raw = {{19{bus.In[31]}}, bus.In[31], bus.In[7],
                         bus.In[30:25], bus.In[11:8], 1'b0};
      3'b011: dec_raw = {bus.In[31:12], 12'b0};
      3'b100: dec_raw = {{11{bus.In[31]}}, bus.In[31], bus.In[19:12],
                         bus.In[20], bus.In[30:21], 1'b0};
      3'b101: dec_raw = {27'b0, bus.In[19:15]};
      default: begin
        dec_raw = '0;
        dec_ill = 1'b1;
      end
    endcase
    dec_imm        = '0;
    dec_imm[31:0]  = dec_raw;
    for (int i = 32; i < XLEN; i++) begin
      dec_imm[i] = dec_raw[31];
    end
  end

  // Buffer next-state: flush wins, then drain (skid refills main), then fill
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire) begin
        if (skid_valid_q) begin
          main_imm_d   = skid_imm_q;
          main_tag_d   = skid_tag_q;
          main_ill_d   = skid_ill_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // in_ready_q guarantees skid is empty whenever in_fire is set
      if (in_fire) begin
        if (!main_valid_q || (out_fire && !skid_valid_q)) begin
          main_valid_d = 1'b1;
          main_imm_d   = dec_imm;
          main_tag_d   = bus.in_tag;
          main_ill_d   = dec_ill;
        end else begin
          skid_valid_d = 1'b1;
          skid_imm_d   = dec_imm;
          skid_tag_d   = bus.in_tag;
          skid_ill_d   = dec_ill;
        end
      end
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers; reset empties both entries and opens the input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.out_valid = main_valid_q;
  assign bus.Imm_Ext   = main_imm_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.illegal   = main_ill_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed format vectors, back-pressure, flush and
// async reset on a 32-bit instance, plus randomized traffic scored against an
// arithmetic reference model; a 64-bit instance checks the wide extension.
module tb_imm_gen_stage;
  localparam int TAG_W = 5;
  localparam int W     = 1 + TAG_W + 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush32 = 1'b0;
  logic flush64 = 1'b0;
  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

  imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32), .bus(bus32.slave)
  );
  imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .bus(bus64.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {illegal, tag, imm[63:0]}, oldest first
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Immediates computed with signed 64-bit arithmetic on the instruction word.
  function automatic logic [63:0] ref_imm(input logic [31:0] instr,
                                          input logic [2:0] src, input int xlen);
    longint sx;
    longint u;
    longint v;
    sx = longint'($signed(instr));
    u  = longint'({32'b0, instr});
    case (src)
      3'd0: v = sx >>> 20;
      3'd1: v = ((sx >>> 25) <<< 5) + ((u >> 7) & 31);
      3'd2: v = ((sx >>> 31) <<< 12) + (((u >> 7) & 1) << 11)
              + (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1);
      3'd3: v = (sx >>> 12) <<< 12;
      3'd4: v = ((sx >>> 31) <<< 20) + (((u >> 12) & 255) << 12)
              + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1);
      3'd5: v = (u >> 15) & 31;
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver (32-bit instance) ----------------
  // Called at posedge+1: apply inputs for the coming edge, score the outputs
  // that are stable now, update the model, then advance one cycle.
  task automatic cycle(input logic iv, input logic [31:0] instr, input logic [2:0] src,
                       input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
    logic [W-1:0] front;
    logic         exp_ir;
    bus32.in_valid  = iv;
    bus32.In        = instr;
    bus32.ImmSrc    = src;
    bus32.in_tag    = tag;
    bus32.out_ready = ordy;
    flush32         = fl;
    exp_ir = (exp_q.size() < 2);
    check("out_valid", 64'(bus32.out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(bus32.in_ready), 64'(exp_ir));
    if (exp_q.size() > 0) begin
      front = exp_q[0];
      check("imm", 64'(bus32.Imm_Ext), front[63:0]);
      check("out_tag", 64'(bus32.out_tag), 64'(front[64 +: TAG_W]));
      check("illegal", 64'(bus32.illegal), 64'(front[W-1]));
      if (ordy) void'(exp_q.pop_front());
    end
    if (fl) exp_q.delete();
    else if (iv && exp_ir) exp_q.push_back({(src >= 3'd6), tag, ref_imm(instr, src, 32)});
    @(posedge clk);
    #1;
  endtask

  // One beat into the empty 64-bit instance with out_ready held high
  task automatic beat64(input logic [31:0] instr, input logic [2:0] src,
                        input logic [TAG_W-1:0] tag);
    bus64.In       = instr;
    bus64.ImmSrc   = src;
    bus64.in_tag   = tag;
    bus64.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    check("x64_valid", 64'(bus64.out_valid), 64'd1);
    check("x64_imm", bus64.Imm_Ext, ref_imm(instr, src, 64));
    check("x64_ill", 64'(bus64.illegal), 64'(src >= 3'd6));
    check("x64_tag", 64'(bus64.out_tag), 64'(tag));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ov32"},  64'(bus32.out_valid), 64'd0);
    check({pfx, "_imm32"}, 64'(bus32.Imm_Ext),   64'd0);
    check({pfx, "_tag32"}, 64'(bus32.out_tag),   64'd0);
    check({pfx, "_ill32"}, 64'(bus32.illegal),   64'd0);
    check({pfx, "_ir32"},  64'(bus32.in_ready),  64'd1);
    check({pfx, "_ov64"},  64'(bus64.out_valid), 64'd0);
    check({pfx, "_imm64"}, bus64.Imm_Ext,        64'd0);
    check({pfx, "_ir64"},  64'(bus64.in_ready),  64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] i3;
    logic [2:0]  s3;
    bus32.in_valid = 1'b0; bus32.In = '0; bus32.ImmSrc = '0; bus32.in_tag = '0;
    bus32.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.In = '0; bus64.ImmSrc = '0; bus64.in_tag = '0;
    bus64.out_ready = 1'b1;

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed formats, each visible one cycle after acceptance
    cycle(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b1, 1'b0);
    check("fmt_I", 64'(bus32.Imm_Ext), 64'hFFFF_FFFF);
    cycle(1'b1, 32'hFE20AE23, 3'd1, 5'd2, 1'b1, 1'b0);
    check("fmt_S", 64'(bus32.Imm_Ext), 64'hFFFF_FFFC);
    cycle(1'b1, 32'hFE000CE3, 3'd2, 5'd3, 1'b1, 1'b0);
    check("fmt_B", 64'(bus32.Imm_Ext), 64'hFFFF_FFF8);
    cycle(1'b1, 32'h123450B7, 3'd3, 5'd4, 1'b1, 1'b0);
    check("fmt_U", 64'(bus32.Imm_Ext), 64'h1234_5000);
    cycle(1'b1, 32'hFFDFF06F, 3'd4, 5'd5, 1'b1, 1'b0);
    check("fmt_J", 64'(bus32.Imm_Ext), 64'hFFFF_FFFC);
    cycle(1'b1, 32'hFFFF8073, 3'd5, 5'd6, 1'b1, 1'b0);
    check("fmt_Z", 64'(bus32.Imm_Ext), 64'h0000_001F);

    // Reserved select, then a legal I beat
    cycle(1'b1, 32'hDEADBEEF, 3'd6, 5'd7, 1'b1, 1'b0);
    check("rsv_imm", 64'(bus32.Imm_Ext), 64'd0);
    check("rsv_ill", 64'(bus32.illegal), 64'd1);
    check("rsv_tag", 64'(bus32.out_tag), 64'd7);
    cycle(1'b1, 32'h7FF00093, 3'd0, 5'd8, 1'b1, 1'b0);
    check("after_rsv_ill", 64'(bus32.illegal), 64'd0);
    check("after_rsv_imm", 64'(bus32.Imm_Ext), 64'h7FF);
    cycle(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // Back-pressure: tags 1,2 fill main/skid, tag 3 waits
    cycle(1'b1, $urandom, 3'($urandom_range(0, 5)), 5'd1, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 3'($urandom_range(0, 5)), 5'd2, 1'b0, 1'b0);
    check("bp_in_ready_low", 64'(bus32.in_ready), 64'd0);
    check("bp_main_tag", 64'(bus32.out_tag), 64'd1);
    i3 = $urandom;
    s3 = 3'($urandom_range(0, 5));
    repeat (3) cycle(1'b1, i3, s3, 5'd3, 1'b0, 1'b0);
    check("bp_tag3_held", 64'(exp_q.size()), 64'd2);
    cycle(1'b1, i3, s3, 5'd3, 1'b1, 1'b0);
    check("bp_tag2_next", 64'(bus32.out_tag), 64'd2);
    cycle(1'b1, i3, s3, 5'd3, 1'b1, 1'b0);
    check("bp_tag3_next", 64'(bus32.out_tag), 64'd3);
    cycle(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // Flush with both entries full and a beat offered
    cycle(1'b1, $urandom, 3'd0, 5'd10, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 3'd1, 5'd11, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 3'd2, 5'd12, 1'b0, 1'b1);
    check("flush_ov", 64'(bus32.out_valid), 64'd0);
    check("flush_ir", 64'(bus32.in_ready), 64'd1);
    repeat (3) cycle(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges with both entries full
    cycle(1'b1, $urandom, 3'd3, 5'd13, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 3'd4, 5'd14, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("arst_ov_now", 64'(bus32.out_valid), 64'd0);
    check("arst_ir_now", 64'(bus32.in_ready), 64'd1);
    exp_q.delete();
    bus32.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("arst");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
    end
    repeat (3) cycle(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // 64-bit extension
    beat64(32'h800000B7, 3'd3, 5'd20);
    check("x64_U", bus64.Imm_Ext, 64'hFFFF_FFFF_8000_0000);
    beat64(32'h7FF00093, 3'd0, 5'd21);
    check("x64_I", bus64.Imm_Ext, 64'h0000_0000_0000_07FF);
    for (int n = 0; n < 30; n++) begin
      beat64($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered immediate generator for the decode stage of the pipelined RISC-V core. It expands every RV32I/RV64I immediate format (I, S, B, U, J) plus the CSR zero-extended uimm to `XLEN` bits. Results are carried in a 2-entry skid buffer with a valid/ready handshake, so back-pressure from execute never creates a combinational ready path. A synchronous flush supports branch and jump redirect.

## Interface
- `XLEN`, 32: output width; legal values 32 or 64.
- `TAG_W`, 5: width of the sideband tag (e.g. rd or ROB index) carried alongside the immediate.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `In` input 32: instruction word.
- `ImmSrc` input 3: format select. 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR uimm), 110/111 reserved.
- `in_tag` input TAG_W: sideband tag captured with the instruction.
- `in_valid` input 1: upstream offers a beat.
- `in_ready` output 1: the stage can accept a beat. Driven from a register.
- `flush` input 1: synchronous pipeline kill.
- `Imm_Ext` output XLEN: extended immediate.
- `out_tag` output TAG_W: tag of the current output beat.
- `illegal` output 1: the current output beat used a reserved `ImmSrc`.
- `out_valid` output 1: output beat present.
- `out_ready` input 1: downstream accepts the beat.

## Operation
- Format rules. Every format sign-extends from `In[31]` to `XLEN`, except Z.
  - I: `In[31:20]`.
  - S: `{In[31:25], In[11:7]}`.
  - B: `{In[31], In[7], In[30:25], In[11:8], 1'b0}`.
  - U: `{In[31:12], 12'b0}`; with `XLEN`=64, bit 31 is sign-extended through bits 63:32.
  - J: `{In[31], In[19:12], In[20], In[30:21], 1'b0}`.
  - Z: `In[19:15]`, zero-extended.
  - Reserved: `Imm_Ext` = 0 and `illegal` = 1.
- Decode is combinational on the input side. The result, tag and illegal flag are written into the buffer entry.
- Storage is two entries: main (drives the outputs) and skid.
- Input handshake: a beat transfers when `in_valid && in_ready`.
- Output handshake: a beat transfers when `out_valid && out_ready`.
- On an accepted beat:
  - If main is empty, or main drains this cycle and skid is empty, the beat goes to main.
  - Otherwise it goes to skid.
- When main drains and skid is full, skid moves to main. An input accepted in the same cycle goes to skid.
- `in_ready` (next) = skid empty after this edge's updates.
- Order is strictly FIFO. No beat is dropped or duplicated.
- Flush has priority over everything. At the edge where `flush`=1:
  - both valids clear;
  - any offered input is discarded, even when `in_valid && in_ready`;
  - `in_ready` is 1 next cycle.
- Reset mid-operation clears both entries immediately and asynchronously. Buffered beats are lost.

## Timing
- Reset values: `out_valid`=0, `Imm_Ext`=0, `out_tag`=0, `illegal`=0, `in_ready`=1, skid empty.
- Latency: 1 cycle from input acceptance to `out_valid` when empty.
- Throughput: 1 beat/cycle while `out_ready`=1.
- While `out_valid && !out_ready`, `Imm_Ext`, `out_tag` and `illegal` hold stable.
- Back-pressure: with main full and `out_ready`=0, one more beat is accepted into skid, and `in_ready` falls on the following cycle.
- After `out_ready` rises, `in_ready` rises one cycle later.
- `in_ready` and `out_valid` have no combinational dependence on `out_ready` or `in_valid`.

## Test plan
- Formats, `XLEN`=32, one beat each, with `out_ready`=1:
  - I, `In`=0xFFF00093 → 0xFFFFFFFF.
  - S, 0xFE20AE23 → 0xFFFFFFFC.
  - B, 0xFE000CE3 → 0xFFFFFFF8.
  - U, 0x123450B7 → 0x12345000.
  - J, 0xFFDFF06F → 0xFFFFFFFC.
  - Z, `In[19:15]`=0x1F → 0x0000001F.
  - Each appears exactly 1 cycle after acceptance.
- `XLEN`=64:
  - U, 0x800000B7 → 0xFFFFFFFF80000000.
  - I, 0x7FF00093 → 0x00000000000007FF.
- Reserved `ImmSrc`=110 with tag 7 → `Imm_Ext`=0, `illegal`=1, `out_tag`=7. The next beat using I format has `illegal`=0.
- Back-pressure: hold `out_ready`=0 and offer tags 1, 2, 3 back-to-back.
  - Tag 1 is in main and tag 2 is in skid; `in_ready`=0 from the cycle after tag 2 is accepted; tag 3 is held.
  - Then raise `out_ready`: the outputs are 1, 2, 3 in order with no gaps after the first, and `Imm_Ext` is stable throughout the stall.
- Flush with both entries full and `in_valid`=1: the next cycle has `out_valid`=0 and `in_ready`=1, and the flushed beats never appear.
- Assert `rst`=0 asynchronously mid-stream, between clock edges: `out_valid` drops immediately, and after release all outputs are at their reset values.
